mem_bridge: RTL
===============

# mem_bridge

Byte-addressed memory front end between the CPU pipeline (IF and MEM stages) and `sram_control`. It arbitrates instruction fetches against data accesses and converts 32-bit byte addresses to 20-bit SRAM word addresses. It issues only whole-word `MEM_LW`/`MEM_SW` operations downstream, performing byte/halfword extraction, sign extension and read-modify-write for sub-word stores itself. It also generates the pipeline stall.

## Interface
- No parameters; op encodings (`MEM_*`) come from `defines.v`.
- `clk50` in 1: system clock, same as `sram_control`.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req_i` in 1: instruction fetch request, held until `if_ready_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_data_o` out 32: fetched word, valid while `if_ready_o`.
- `if_ready_o` out 1: one-cycle fetch completion pulse.
- `mem_op_i` in 4: data op (`MEM_LW/LH/LHU/LB/LBU/SW/SH/SB`); 0 means no request. Held until `mem_ready_o`.
- `mem_addr_i` in 32: data byte address.
- `mem_wdata_i` in 32: store data, right-aligned for SB/SH.
- `mem_rdata_o` out 32: load result, extended per op.
- `mem_ready_o` out 1: one-cycle data completion pulse.
- `mem_exc_o` out 1: misaligned access, pulsed together with `mem_ready_o`.
- `stall_o` out 1: combinational. High while any request is pending and its ready has not pulsed.
- `ramOp_o` out 4: to `sram_control`, registered; only 0, `MEM_LW` or `MEM_SW`.
- `ramAddr_o` out 20: SRAM word address, registered.
- `storeData_o` out 32: full word to write, registered.
- `loadData_i` in 32: word from `sram_control`.
- `success_i` in 1: completion pulse from `sram_control`.

## Operation
- FSM states: IDLE, IRD, DRD, DWR, GAP.
- IDLE: a data request has priority over fetch.
  - Misaligned data access goes to GAP with `mem_exc_o`, and no SRAM access is made. Misaligned means LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
  - LW/LH/LHU/LB/LBU/SH/SB: register `ramAddr_o`=addr[21:2] and `ramOp_o`=`MEM_LW`, then go to DRD.
  - SW: register `storeData_o`=wdata and `ramOp_o`=`MEM_SW`, then go to DWR.
  - Otherwise, if `if_req_i`: `ramOp_o`=`MEM_LW`, addr from `if_addr_i`, then go to IRD. Fetch misalignment is ignored: addr[1:0] is dropped.
- IRD: on `success_i`, capture `loadData_i` into `if_data_o`, clear `ramOp_o`, go to GAP.
- DRD: on `success_i`:
  - Loads: capture the extracted lane, clear `ramOp_o`, go to GAP.
  - SB/SH: merge wdata into the read word at lane addr[1:0], load `storeData_o` with the merged word, go to GAP with an RMW flag set.
- DWR: on `success_i`, clear `ramOp_o`, go to GAP.
- GAP: one cycle with `ramOp_o`=0. This lets `sram_control` fall back to IDLE.
  - If the RMW flag is set: clear the flag, set `ramOp_o`=`MEM_SW`, go to DWR. No ready pulse.
  - Otherwise: pulse the owning ready (and `mem_exc_o` if applicable), go to IDLE.
- Lanes are little-endian: byte k is bits [8k+7:8k].
  - LB/LH sign-extend from the lane MSB; LBU/LHU zero-extend.
  - Halfword lanes: addr[1]=0 is [15:0], addr[1]=1 is [31:16].
- `stall_o` = (`mem_op_i`≠0 & !`mem_ready_o`) | (`if_req_i` & !`if_ready_o`).
- A fetch arriving mid-data-transaction waits. The CPU holds both requests stable while stalled.

## Timing
- Reset (async, `rst_n`=0): state IDLE; every output and internal register is 0. `ramOp_o`=0 forces `sram_control` idle. Reset mid-transaction abandons it; no ready pulse is produced, and a partial RMW never writes.
- `ramOp_o` is asserted the cycle after acceptance and held constant until `success_i`.
- With `sram_control` (read success 2 cycles after op, write success 4 cycles after op):
  - Aligned load/fetch: ready at T+4.
  - SW: ready at T+6.
  - SB/SH: ready at T+10.
  - Misaligned access: ready at T+2.
  - T is the acceptance cycle in IDLE.
- Read data and `if_data_o`/`mem_rdata_o` are valid only during the ready pulse. Both hold their value afterwards, but this is not guaranteed to consumers.
- `success_i` outside IRD/DRD/DWR is ignored.

## Structure
- New shared constants go in `defines.v`: `BRIDGE_IDLE`..`BRIDGE_GAP` state codes and a `MEM_NONE` (4'b0) alias.
- One sub-module: `mem_lane_unit`. It is combinational and does load extraction/extension and store merging from op, addr[1:0], word and wdata.

## Test plan
- Reset mid-DRD (assert `rst_n`=0 at T+2) → all outputs 0, no `mem_ready_o`. A new LW after release completes normally.
- LB at 0x00000003, word 0x80FF_1234 → `ramAddr_o`=0, `mem_rdata_o`=0xFFFF_FF80. LBU same access → 0x0000_0080.
- SB 0xAB at 0x00000006 over word 0x1122_3344 → read then write at `ramAddr_o`=1 with `storeData_o`=0x11AB_3344; one `mem_ready_o`, 10 cycles.
- Simultaneous `if_req_i`(0x100) and LW(0x200) → the data access is served first (`ramAddr_o`=0x80), then the fetch (0x40). `stall_o` stays high until `if_ready_o`, and a GAP cycle with `ramOp_o`=0 separates them.
- LH at 0x00000001 → `mem_exc_o` and `mem_ready_o` at T+2; `ramOp_o` never leaves 0.
- SW 0xDEADBEEF at 0x10 followed by LW 0x10 → `mem_rdata_o`=0xDEADBEEF; GAP is observed between the transactions.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared op encodings, bridge FSM states and access-classification helpers
// for the CPU-to-SRAM memory bridge.
package mem_bridge_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LW   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LHU  = 4'd3;
  localparam logic [3:0] MEM_LB   = 4'd4;
  localparam logic [3:0] MEM_LBU  = 4'd5;
  localparam logic [3:0] MEM_SW   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SB   = 4'd8;

  typedef enum logic [2:0] {
    BRIDGE_IDLE = 3'd0,
    BRIDGE_IRD  = 3'd1,
    BRIDGE_DRD  = 3'd2,
    BRIDGE_DWR  = 3'd3,
    BRIDGE_GAP  = 3'd4
  } bridge_state_e;

  function automatic logic is_data_op(input logic [3:0] op);
    case (op)
      MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU,
      MEM_SW, MEM_SH, MEM_SB: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      MEM_LW, MEM_SW:          return (lane != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: return lane[0];
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_subword_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH);
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: extracts/extends load lanes from an SRAM word and
// merges right-aligned sub-word store data into it (little-endian lanes).
module mem_lane_unit
  import mem_bridge_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    case (lane_i)
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      2'd3:    w_byte = word_i[31:24];
      default: w_byte = word_i[7:0];
    endcase
    w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (op_i)
      MEM_LB:  load_o = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: load_o = {24'd0, w_byte};
      MEM_LH:  load_o = {{16{w_half[15]}}, w_half};
      MEM_LHU: load_o = {16'd0, w_half};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    if (op_i == MEM_SB) begin
      case (lane_i)
        2'd1:    merged_o[15:8]  = wdata_i[7:0];
        2'd2:    merged_o[23:16] = wdata_i[7:0];
        2'd3:    merged_o[31:24] = wdata_i[7:0];
        default: merged_o[7:0]   = wdata_i[7:0];
      endcase
    end else if (op_i == MEM_SH) begin
      if (lane_i[1]) merged_o[31:16] = wdata_i;
      else           merged_o[15:0]  = wdata_i;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Arbitrates IF fetches against MEM data accesses onto a word-only SRAM
// controller; sub-word stores are done as read-modify-write.
module mem_bridge
  import mem_bridge_pkg::*;
(
  input  logic          clk50,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic [31:0]   if_data_o,
  output logic          if_ready_o,
  input  logic [3:0]    mem_op_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   mem_wdata_i,
  output logic [31:0]   mem_rdata_o,
  output logic          mem_ready_o,
  output logic          mem_exc_o,
  output logic          stall_o,
  output logic [3:0]    ramOp_o,
  output logic [19:0]   ramAddr_o,
  output logic [31:0]   storeData_o,
  input  logic [31:0]   loadData_i,
  input  logic          success_i,
  output bridge_state_e dbg_state_o
);

  bridge_state_e r_state, w_state_nxt;
  logic [3:0]  r_ram_op,     w_ram_op_nxt;
  logic [19:0] r_ram_addr,   w_ram_addr_nxt;
  logic [31:0] r_store,      w_store_nxt;
  logic [3:0]  r_op,         w_op_nxt;
  logic [1:0]  r_lane,       w_lane_nxt;
  logic [15:0] r_wdata,      w_wdata_nxt;
  logic        r_owner_data, w_owner_data_nxt;
  logic        r_rmw,        w_rmw_nxt;
  logic        r_exc,        w_exc_nxt;
  logic        r_exc_wait,   w_exc_wait_nxt;
  logic [31:0] r_if_data,    w_if_data_nxt;
  logic [31:0] r_rdata,      w_rdata_nxt;

  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic        w_gap_done;
  logic        w_unused;

  assign w_unused = ^{if_addr_i[31:22], if_addr_i[1:0], mem_addr_i[31:22]};

  mem_lane_unit u_lane (
    .op_i     (r_op),
    .lane_i   (r_lane),
    .word_i   (loadData_i),
    .wdata_i  (r_wdata),
    .load_o   (w_load),
    .merged_o (w_merged)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_ram_op_nxt     = r_ram_op;
    w_ram_addr_nxt   = r_ram_addr;
    w_store_nxt      = r_store;
    w_op_nxt         = r_op;
    w_lane_nxt       = r_lane;
    w_wdata_nxt      = r_wdata;
    w_owner_data_nxt = r_owner_data;
    w_rmw_nxt        = r_rmw;
    w_exc_nxt        = r_exc;
    w_exc_wait_nxt   = r_exc_wait;
    w_if_data_nxt    = r_if_data;
    w_rdata_nxt      = r_rdata;
    case (r_state)
      BRIDGE_IDLE: begin
        if (is_data_op(mem_op_i)) begin
          w_owner_data_nxt = 1'b1;
          w_op_nxt         = mem_op_i;
          w_lane_nxt       = mem_addr_i[1:0];
          w_wdata_nxt      = mem_wdata_i[15:0];
          if (is_misaligned(mem_op_i, mem_addr_i[1:0])) begin
            // Faults linger one extra GAP cycle so they complete two cycles after acceptance.
            w_exc_nxt      = 1'b1;
            w_exc_wait_nxt = 1'b1;
            w_state_nxt    = BRIDGE_GAP;
          end else if (mem_op_i == MEM_SW) begin
            w_exc_nxt      = 1'b0;
            w_ram_addr_nxt = mem_addr_i[21:2];
            w_store_nxt    = mem_wdata_i;
            w_ram_op_nxt   = MEM_SW;
            w_state_nxt    = BRIDGE_DWR;
          end else begin
            w_exc_nxt      = 1'b0;
            w_ram_addr_nxt = mem_addr_i[21:2];
            w_ram_op_nxt   = MEM_LW;
            w_state_nxt    = BRIDGE_DRD;
          end
        end else if (if_req_i) begin
          w_owner_data_nxt = 1'b0;
          w_exc_nxt        = 1'b0;
          w_ram_addr_nxt   = if_addr_i[21:2];
          w_ram_op_nxt     = MEM_LW;
          w_state_nxt      = BRIDGE_IRD;
        end
      end
      BRIDGE_IRD: begin
        if (success_i) begin
          w_if_data_nxt = loadData_i;
          w_ram_op_nxt  = MEM_NONE;
          w_state_nxt   = BRIDGE_GAP;
        end
      end
      BRIDGE_DRD: begin
        if (success_i) begin
          if (is_subword_store(r_op)) begin
            w_store_nxt = w_merged;
            w_rmw_nxt   = 1'b1;
          end else begin
            w_rdata_nxt = w_load;
          end
          w_ram_op_nxt = MEM_NONE;
          w_state_nxt  = BRIDGE_GAP;
        end
      end
      BRIDGE_DWR: begin
        if (success_i) begin
          w_ram_op_nxt = MEM_NONE;
          w_state_nxt  = BRIDGE_GAP;
        end
      end
      BRIDGE_GAP: begin
        if (r_exc_wait) begin
          w_exc_wait_nxt = 1'b0;
        end else if (r_rmw) begin
          w_rmw_nxt    = 1'b0;
          w_ram_op_nxt = MEM_SW;
          w_state_nxt  = BRIDGE_DWR;
        end else begin
          w_state_nxt = BRIDGE_IDLE;
        end
      end
      default: w_state_nxt = BRIDGE_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BRIDGE_IDLE;
      r_ram_op     <= MEM_NONE;
      r_ram_addr   <= '0;
      r_store      <= '0;
      r_op         <= MEM_NONE;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_owner_data <= 1'b0;
      r_rmw        <= 1'b0;
      r_exc        <= 1'b0;
      r_exc_wait   <= 1'b0;
      r_if_data    <= '0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ram_op     <= w_ram_op_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_store      <= w_store_nxt;
      r_op         <= w_op_nxt;
      r_lane       <= w_lane_nxt;
      r_wdata      <= w_wdata_nxt;
      r_owner_data <= w_owner_data_nxt;
      r_rmw        <= w_rmw_nxt;
      r_exc        <= w_exc_nxt;
      r_exc_wait   <= w_exc_wait_nxt;
      r_if_data    <= w_if_data_nxt;
      r_rdata      <= w_rdata_nxt;
    end
  end

  // Handshake: each request is held until its ready pulses for exactly one cycle in GAP.
  assign w_gap_done  = (r_state == BRIDGE_GAP) && !r_rmw && !r_exc_wait;
  assign if_ready_o  = w_gap_done && !r_owner_data;
  assign mem_ready_o = w_gap_done && r_owner_data;
  assign mem_exc_o   = mem_ready_o && r_exc;
  assign stall_o     = ((mem_op_i != MEM_NONE) && !mem_ready_o) || (if_req_i && !if_ready_o);

  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_rdata;
  assign ramOp_o     = r_ram_op;
  assign ramAddr_o   = r_ram_addr;
  assign storeData_o = r_store;
  assign dbg_state_o = r_state;

endmodule
